// File: rtl/tx_seq_recorder_pkg.sv
// tx_seq_recorder_pkg: source encoding and burst limits shared by the tx arbiter and its sequence recorder
package Tx_Arbiter_Package;
    typedef enum logic [2:0] {
        NO_REQ     = 3'd0,
        A2P_1      = 3'd1,
        A2P_2      = 3'd2,
        MASTER     = 3'd3,
        RX_CFG_CPL = 3'd4,
        RX_ERR     = 3'd5
    } Tx_Arbiter_Sources_t;
    localparam int MAX_WR = 4;
    localparam int MAX_RD = 2;
    function automatic logic in_range(logic [2:0] mode, int max_n);
        return mode != 3'd0 && int'(mode) <= max_n;
    endfunction
endpackage

// File: rtl/tx_seq_recorder_if.sv
// tx_seq_recorder_if: push/pop bus between the tx arbiter and the sequence recorder
interface Tx_Arbiter_Sequence_Recorder
    import Tx_Arbiter_Package::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
);
    logic                  wr_en;
    logic [2:0]            wr_mode;
    Tx_Arbiter_Sources_t   wr_data_1;
    Tx_Arbiter_Sources_t   wr_data_2;
    Tx_Arbiter_Sources_t   wr_data_3;
    Tx_Arbiter_Sources_t   wr_data_4;
    logic                  rd_en;
    logic [1:0]            rd_mode;
    Tx_Arbiter_Sources_t   rd_data_1;
    Tx_Arbiter_Sources_t   rd_data_2;
    logic                  empty;
    logic                  full;
    logic [ADDR_WIDTH:0]   available;
    modport TX_ARBITER_SEQUENCE_RECORDER (
        output wr_en, wr_mode, wr_data_1, wr_data_2, wr_data_3, wr_data_4, rd_en, rd_mode,
        input  rd_data_1, rd_data_2, empty, full, available
    );
    modport SEQUENCE_RECORDER_TX_ARBITER (
        input  wr_en, wr_mode, wr_data_1, wr_data_2, wr_data_3, wr_data_4, rd_en, rd_mode,
        output rd_data_1, rd_data_2, empty, full, available
    );
endinterface

// File: rtl/tx_seq_recorder_mem.sv
// tx_seq_recorder_mem: circular register file, four consecutive write slots and two show-ahead reads
module tx_seq_recorder_mem
    import Tx_Arbiter_Package::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                clk,
    input  logic [MAX_WR-1:0]   we,
    input  logic [ADDR_WIDTH-1:0] wr_ptr,
    input  Tx_Arbiter_Sources_t wr_data [MAX_WR],
    input  logic [ADDR_WIDTH-1:0] rd_ptr,
    output Tx_Arbiter_Sources_t rd_data [MAX_RD]
);
    Tx_Arbiter_Sources_t mem [FIFO_DEPTH];
    always_ff @(posedge clk)
        for (int i = 0; i < MAX_WR; i++)
            if (we[i]) mem[wr_ptr + ADDR_WIDTH'(i)] <= wr_data[i];
    always_comb
        for (int i = 0; i < MAX_RD; i++)
            rd_data[i] = mem[rd_ptr + ADDR_WIDTH'(i)];
endmodule

// File: rtl/tx_seq_recorder.sv
// tx_seq_recorder: multi-push/multi-pop source-order FIFO; bursts that do not fit are rejected whole
module tx_seq_recorder
    import Tx_Arbiter_Package::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic clk,
    input  logic arst_n,
    Tx_Arbiter_Sequence_Recorder.SEQUENCE_RECORDER_TX_ARBITER bus,
    output logic ovf_err,
    output logic udf_err
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         count, avail, wr_num, rd_num;
    logic                  wr_req, rd_req, wr_ok, rd_ok;
    logic [MAX_WR-1:0]     we;
    Tx_Arbiter_Sources_t   wr_data [MAX_WR];
    Tx_Arbiter_Sources_t   rd_data [MAX_RD];
    assign avail   = DEPTH - count;
    assign wr_data = '{bus.wr_data_1, bus.wr_data_2, bus.wr_data_3, bus.wr_data_4};
    // fit checks use start-of-cycle occupancy; a same-cycle pop never makes room for a push
    always_comb begin
        wr_req = bus.wr_en && in_range(bus.wr_mode, MAX_WR);
        rd_req = bus.rd_en && in_range({1'b0, bus.rd_mode}, MAX_RD);
        wr_ok  = wr_req && CW'(bus.wr_mode) <= avail;
        rd_ok  = rd_req && CW'(bus.rd_mode) <= count;
        wr_num = wr_ok ? CW'(bus.wr_mode) : '0;
        rd_num = rd_ok ? CW'(bus.rd_mode) : '0;
        for (int i = 0; i < MAX_WR; i++)
            we[i] = wr_ok && int'(bus.wr_mode) > i;
    end
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + ADDR_WIDTH'(wr_num);
            rd_ptr  <= rd_ptr + ADDR_WIDTH'(rd_num);
            count   <= count + wr_num - rd_num;
            ovf_err <= wr_req && !wr_ok;
            udf_err <= rd_req && !rd_ok;
        end
    end
    tx_seq_recorder_mem #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clk     (clk),
        .we      (we),
        .wr_ptr  (wr_ptr),
        .wr_data (wr_data),
        .rd_ptr  (rd_ptr),
        .rd_data (rd_data)
    );
    assign bus.empty     = count == '0;
    assign bus.full      = count == DEPTH;
    assign bus.available = avail;
    assign bus.rd_data_1 = count == '0 ? NO_REQ : rd_data[0];
    assign bus.rd_data_2 = count < CW'(2) ? NO_REQ : rd_data[1];
endmodule

// File: tb/tb_tx_seq_recorder.sv
// tb_tx_seq_recorder: directed push/pop scenarios with hand-computed expectations
module tb_tx_seq_recorder;
    import Tx_Arbiter_Package::*;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic ovf_err, udf_err;
    int checks = 0;
    int failures = 0;
    Tx_Arbiter_Sequence_Recorder bus ();
    tx_seq_recorder dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .bus     (bus),
        .ovf_err (ovf_err),
        .udf_err (udf_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic idle();
        bus.wr_en = 1'b0; bus.wr_mode = 3'd0; bus.rd_en = 1'b0; bus.rd_mode = 2'd0;
        bus.wr_data_1 = NO_REQ; bus.wr_data_2 = NO_REQ; bus.wr_data_3 = NO_REQ; bus.wr_data_4 = NO_REQ;
    endtask
    task automatic push(input logic [2:0] n, input Tx_Arbiter_Sources_t d1, input Tx_Arbiter_Sources_t d2,
                        input Tx_Arbiter_Sources_t d3, input Tx_Arbiter_Sources_t d4);
        bus.wr_en = 1'b1; bus.wr_mode = n;
        bus.wr_data_1 = d1; bus.wr_data_2 = d2; bus.wr_data_3 = d3; bus.wr_data_4 = d4;
    endtask
    task automatic pop(input logic [1:0] m);
        bus.rd_en = 1'b1; bus.rd_mode = m;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask
    initial begin
        Tx_Arbiter_Sources_t a, b;
        idle();
        #2;
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_avail", bus.available, 4);
        chk("rst_rd1", bus.rd_data_1, NO_REQ);
        chk("rst_rd2", bus.rd_data_2, NO_REQ);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_udf", udf_err, 0);
        arst_n = 1'b1;
        push(3'd4, A2P_1, A2P_2, MASTER, RX_ERR);
        tick();
        chk("s1_full", bus.full, 1);
        chk("s1_avail", bus.available, 0);
        chk("s1_rd1", bus.rd_data_1, A2P_1);
        chk("s1_rd2", bus.rd_data_2, A2P_2);
        push(3'd1, RX_CFG_CPL, NO_REQ, NO_REQ, NO_REQ);
        tick();
        chk("s2_ovf", ovf_err, 1);
        chk("s2_full", bus.full, 1);
        chk("s2_rd1", bus.rd_data_1, A2P_1);
        chk("s2_rd2", bus.rd_data_2, A2P_2);
        tick();
        chk("s2_ovf_clr", ovf_err, 0);
        pop(2'd2);
        tick();
        chk("s2_pop_rd1", bus.rd_data_1, MASTER);
        chk("s2_pop_rd2", bus.rd_data_2, RX_ERR);
        chk("s2_pop_avail", bus.available, 2);
        pop(2'd1);
        tick();
        chk("s3_rd1", bus.rd_data_1, RX_ERR);
        chk("s3_rd2", bus.rd_data_2, NO_REQ);
        pop(2'd2);
        tick();
        chk("s3_udf", udf_err, 1);
        chk("s3_avail", bus.available, 3);
        chk("s3_keep_rd1", bus.rd_data_1, RX_ERR);
        push(3'd0, MASTER, MASTER, MASTER, MASTER);
        pop(2'd3);
        tick();
        chk("s3_udf_clr", udf_err, 0);
        chk("noop_ovf0", ovf_err, 0);
        chk("noop_avail0", bus.available, 3);
        push(3'd5, MASTER, MASTER, MASTER, MASTER);
        pop(2'd0);
        tick();
        chk("noop_ovf5", ovf_err, 0);
        chk("noop_udf0", udf_err, 0);
        chk("noop_avail5", bus.available, 3);
        pop(2'd1);
        tick();
        chk("s3_empty", bus.empty, 1);
        chk("s3_empty_rd1", bus.rd_data_1, NO_REQ);
        chk("s3_empty_avail", bus.available, 4);
        push(3'd2, A2P_1, A2P_2, NO_REQ, NO_REQ);
        #1;
        chk("no_bypass_rd1", bus.rd_data_1, NO_REQ);
        tick();
        chk("s4_fill_rd1", bus.rd_data_1, A2P_1);
        chk("s4_fill_rd2", bus.rd_data_2, A2P_2);
        for (int k = 0; k < 10; k++) begin
            a = Tx_Arbiter_Sources_t'(3'(1 + k % 5));
            b = Tx_Arbiter_Sources_t'(3'(1 + (k + 1) % 5));
            push(3'd2, a, b, NO_REQ, NO_REQ);
            pop(2'd2);
            tick();
            chk($sformatf("s4_rd1_%0d", k), bus.rd_data_1, a);
            chk($sformatf("s4_rd2_%0d", k), bus.rd_data_2, b);
            chk($sformatf("s4_avail_%0d", k), bus.available, 2);
            chk($sformatf("s4_ovf_%0d", k), ovf_err, 0);
        end
        push(3'd3, MASTER, MASTER, MASTER, NO_REQ);
        pop(2'd1);
        tick();
        chk("no_pop_credit_ovf", ovf_err, 1);
        chk("no_pop_credit_avail", bus.available, 3);
        chk("no_pop_credit_rd1", bus.rd_data_1, A2P_1);
        push(3'd3, MASTER, RX_CFG_CPL, A2P_2, NO_REQ);
        tick();
        chk("s5_pre_full", bus.full, 1);
        push(3'd1, RX_ERR, NO_REQ, NO_REQ, NO_REQ);
        pop(2'd1);
        tick();
        chk("s5_ovf", ovf_err, 1);
        chk("s5_udf", udf_err, 0);
        chk("s5_avail", bus.available, 1);
        chk("s5_rd1", bus.rd_data_1, MASTER);
        chk("s5_rd2", bus.rd_data_2, RX_CFG_CPL);
        #2;
        arst_n = 1'b0;
        #1;
        chk("s6_empty", bus.empty, 1);
        chk("s6_avail", bus.available, 4);
        chk("s6_full", bus.full, 0);
        chk("s6_rd1", bus.rd_data_1, NO_REQ);
        chk("s6_ovf", ovf_err, 0);
        #2;
        arst_n = 1'b1;
        push(3'd1, A2P_2, NO_REQ, NO_REQ, NO_REQ);
        tick();
        chk("post_rst_rd1", bus.rd_data_1, A2P_2);
        chk("post_rst_rd2", bus.rd_data_2, NO_REQ);
        chk("post_rst_avail", bus.available, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
